ctrl_sequencer: RTL

//  Control unit feeding DATA_PATH: a 5-state multicycle FSM that decodes the fetched

---
 rtl/ctrl_sequencer_pkg.sv | 109 ++++++++++
 rtl/ctrl_decode.sv | 165 ++++++++++++++++
 rtl/ctrl_sequencer.sv | 63 ++++++
 3 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// rtl/ctrl_sequencer_pkg.sv - opcode/funct codes, ALU codes, state encodings, CTRL bit map
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // CTRL bit indices
  localparam int B_PC_LOAD   = 0;
  localparam int B_PC_SEL_1  = 1;
  localparam int B_PC_SEL_2  = 2;
  localparam int B_PC_SEL_3  = 3;
  localparam int B_IR_LOAD   = 4;
  localparam int B_RF_READ   = 6;
  localparam int B_RF_WRITE  = 7;
  localparam int B_R1_SEL_1  = 8;
  localparam int B_SP_LOAD   = 9;
  localparam int B_OP1_SEL_1 = 10;
  localparam int B_OP2_SEL_1 = 11;
  localparam int B_OP2_SEL_2 = 12;
  localparam int B_OP2_SEL_3 = 13;
  localparam int B_OP2_SEL_4 = 14;
  localparam int B_ALU_LSB   = 15;
  localparam int B_MA_SEL_1  = 21;
  localparam int B_MA_SEL_2  = 22;
  localparam int B_MD_SEL_1  = 23;
  localparam int B_MEM_READ  = 24;
  localparam int B_MEM_WRITE = 25;
  localparam int B_WD_SEL_1  = 26;
  localparam int B_WD_SEL_2  = 27;
  localparam int B_WD_SEL_3  = 28;
  localparam int B_WA_SEL_1  = 29;
  localparam int B_WA_SEL_2  = 30;
  localparam int B_WA_SEL_3  = 31;

  // ALU operation codes
  localparam logic [5:0] ALU_NONE = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_MUL  = 6'd3;
  localparam logic [5:0] ALU_SHR  = 6'd4;
  localparam logic [5:0] ALU_SHL  = 6'd5;
  localparam logic [5:0] ALU_AND  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_NOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] F_SLL = 6'h01;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [5:0] F_MUL = 6'h2c;

  // Write-address source: rd, rt, r31, R0
  localparam logic [1:0] WA_RD  = 2'd0;
  localparam logic [1:0] WA_RT  = 2'd1;
  localparam logic [1:0] WA_R31 = 2'd2;
  localparam logic [1:0] WA_R0  = 2'd3;

  // Write-data source: ALU result, memory data, immediate (lui), return PC (jal)
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_IMM = 2'd2;
  localparam logic [1:0] WD_PC  = 2'd3;

  // ALU operation for an R-type funct; ALU_NONE marks jr and unknown functs
  function automatic logic [5:0] funct_alu(input logic [5:0] f);
    case (f)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_MUL:   funct_alu = ALU_MUL;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_NOR:   funct_alu = ALU_NOR;
      F_SLT:   funct_alu = ALU_SLT;
      F_SLL:   funct_alu = ALU_SHL;
      F_SRL:   funct_alu = ALU_SHR;
      default: funct_alu = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational IR + state + ZERO to CTRL word decoder
module ctrl_decode
  import ctrl_sequencer_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 32
) (
  input  state_e              state_i,
  input  logic [DATA_W-1:0]   ir_i,
  input  logic                zero_i,
  output logic [CTRL_W-1:0]   ctrl_o
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              unused_ir;
  logic [CTRL_W-1:0] exe_w;
  logic [CTRL_W-1:0] mem_w;
  logic [CTRL_W-1:0] wb_w;
  logic [5:0]        alu;
  logic              rf_wr;
  logic [1:0]        wa_k;
  logic [1:0]        wd_k;
  logic              is_push;

  assign opcode    = ir_i[31:26];
  assign funct     = ir_i[5:0];
  assign unused_ir = ^ir_i[25:6];
  assign is_push   = (opcode == OP_PUSH);

  // Per-instruction words: EXE settings, MEM-only strobes, WB-only additions
  always_comb begin
    exe_w = '0;
    mem_w = '0;
    wb_w  = '0;
    alu   = ALU_NONE;
    rf_wr = 1'b0;
    wa_k  = WA_RD;
    wd_k  = WD_ALU;

    exe_w[B_RF_READ] = 1'b1;
    // default next PC is pc+1
    wb_w[B_PC_LOAD]  = 1'b1;
    wb_w[B_PC_SEL_3] = 1'b1;
    wb_w[B_PC_SEL_1] = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        alu = funct_alu(funct);
        if (funct == F_SLL || funct == F_SRL) begin
          exe_w[B_OP2_SEL_3] = 1'b1;
          exe_w[B_OP2_SEL_1] = 1'b1;
          rf_wr = 1'b1;
        end else if (funct == F_JR) begin
          wb_w[B_PC_SEL_1] = 1'b0;
        end else if (alu != ALU_NONE) begin
          exe_w[B_OP2_SEL_4] = 1'b1;
          rf_wr = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_MULI: begin
        alu = (opcode == OP_ADDI) ? ALU_ADD : (opcode == OP_SLTI) ? ALU_SLT : ALU_MUL;
        exe_w[B_OP2_SEL_2] = 1'b1;
        rf_wr = 1'b1;
        wa_k  = WA_RT;
      end
      OP_ANDI, OP_ORI: begin
        alu   = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        rf_wr = 1'b1;
        wa_k  = WA_RT;
      end
      OP_LUI: begin
        rf_wr = 1'b1;
        wa_k  = WA_RT;
        wd_k  = WD_IMM;
      end
      OP_LW: begin
        alu = ALU_ADD;
        exe_w[B_OP2_SEL_2] = 1'b1;
        mem_w[B_MEM_READ]  = 1'b1;
        rf_wr = 1'b1;
        wa_k  = WA_RT;
        wd_k  = WD_MEM;
      end
      OP_SW: begin
        alu = ALU_ADD;
        exe_w[B_OP2_SEL_2] = 1'b1;
        mem_w[B_MEM_WRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu = ALU_SUB;
        exe_w[B_OP2_SEL_4] = 1'b1;
        if ((opcode == OP_BEQ) ? zero_i : !zero_i)
          wb_w[B_PC_SEL_2] = 1'b1;
      end
      OP_JMP, OP_JAL: begin
        wb_w[B_PC_SEL_3] = 1'b0;
        wb_w[B_PC_SEL_1] = 1'b0;
        if (opcode == OP_JAL) begin
          rf_wr = 1'b1;
          wa_k  = WA_R31;
          wd_k  = WD_PC;
        end
      end
      OP_PUSH, OP_POP: begin
        // stack pointer +/- 1 through op1 = SP, op2 = constant 1
        alu = is_push ? ALU_SUB : ALU_ADD;
        exe_w[B_OP1_SEL_1] = 1'b1;
        exe_w[B_OP2_SEL_3] = 1'b1;
        exe_w[B_R1_SEL_1]  = is_push;
        wb_w[B_SP_LOAD]    = 1'b1;
        if (is_push) begin
          mem_w[B_MEM_WRITE] = 1'b1;
          mem_w[B_MA_SEL_1]  = 1'b1;
          mem_w[B_MD_SEL_1]  = 1'b1;
        end else begin
          mem_w[B_MEM_READ] = 1'b1;
          rf_wr = 1'b1;
          wa_k  = WA_R0;
          wd_k  = WD_MEM;
        end
      end
      default: ;
    endcase

    exe_w[B_ALU_LSB +: 6] = alu;

    if (rf_wr) begin
      wb_w[B_RF_WRITE] = 1'b1;
      case (wa_k)
        WA_RD:   wb_w[B_WA_SEL_3] = 1'b1;
        WA_RT:   begin wb_w[B_WA_SEL_3] = 1'b1; wb_w[B_WA_SEL_1] = 1'b1; end
        WA_R31:  wb_w[B_WA_SEL_2] = 1'b1;
        default: ;
      endcase
      case (wd_k)
        WD_ALU:  wb_w[B_WD_SEL_3] = 1'b1;
        WD_MEM:  begin wb_w[B_WD_SEL_3] = 1'b1; wb_w[B_WD_SEL_1] = 1'b1; end
        WD_IMM:  begin wb_w[B_WD_SEL_3] = 1'b1; wb_w[B_WD_SEL_2] = 1'b1; end
        default: ;
      endcase
    end
  end

  // Select the control word for the state being entered
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o[B_MA_SEL_2] = 1'b1;
        ctrl_o[B_MEM_READ] = 1'b1;
        ctrl_o[B_IR_LOAD]  = 1'b1;
      end
      ST_DECODE: begin
        ctrl_o[B_RF_READ]  = 1'b1;
        ctrl_o[B_R1_SEL_1] = is_push;
      end
      ST_EXE:  ctrl_o = exe_w;
      ST_MEM:  ctrl_o = exe_w | mem_w;
      ST_WB:   ctrl_o = exe_w | wb_w;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - 5-state multicycle control FSM with registered CTRL bus
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic [2:0]        STATE
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Fixed cyclic sequence; IR reloads only when leaving FETCH
  always_comb begin
    state_d = ST_FETCH;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
        ir_d    = INSTRUCTION;
      end
      ST_DECODE: state_d = ST_EXE;
      ST_EXE:    state_d = ST_MEM;
      ST_MEM:    state_d = ST_WB;
      default:   state_d = ST_FETCH;
    endcase
  end

  // CTRL is registered, so decode the word for the state being entered
  ctrl_decode #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .state_i (state_d),
    .ir_i    (ir_d),
    .zero_i  (ZERO),
    .ctrl_o  (ctrl_d)
  );

  // State, IR copy and CTRL registers; reset abandons any instruction in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign CTRL  = ctrl_q;
  assign STATE = state_q;

endmodule
